apb_slave_regfile18: RTL and testbench

APB_SLAVE_REGFILE18 -- requirements
Module: apb_slave_regfile18

---
 rtl/apb_slave_regfile18.sv | 189 ++++++++++++++++++
 tb/tb_apb_slave_regfile18.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regfile18.sv
// APB slave register file: CTRL/STATUS/MASK/SCRATCH0-4 with programmable wait
// states, W1C sticky STATUS bits and a registered masked interrupt.
module apb_slave_regfile18 #(
    parameter int PADDR_WIDTH18  = 32,
    parameter int PWDATA_WIDTH18 = 32,
    parameter int PRDATA_WIDTH18 = 32,
    parameter int PSEL_INDEX18   = 0,
    parameter int WAIT_STATES18  = 1
) (
    input  logic                      pclock18,
    input  logic                      preset18,
    input  logic [PADDR_WIDTH18-1:0]  paddr18,
    input  logic                      prwd18,
    input  logic [PWDATA_WIDTH18-1:0] pwdata18,
    input  logic                      penable18,
    input  logic [15:0]               psel18,
    input  logic [7:0]                hw_event18,
    output logic                      pready18,
    output logic [PRDATA_WIDTH18-1:0] prdata18,
    output logic                      pslverr18,
    output logic                      irq18
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS_WAIT,
        ACCESS_DONE
    } state_e;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES18);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] wdata_q, wdata_d;

    logic [7:0]  ctrl_q, ctrl_d;
    logic [7:0]  status_q, status_d;
    logic [7:0]  mask_q, mask_d;
    logic [31:0] scratch_q [5];
    logic [31:0] scratch_d [5];
    logic        irq_q, irq_d;

    logic        sel;
    logic        setup;
    logic        commit;
    logic [7:0]  status_clr;
    logic [31:0] rd_word;

    assign sel    = psel18[PSEL_INDEX18];
    assign setup  = sel && !penable18;
    assign commit = pready18 && wr_q && !err_q;
    assign irq18  = irq_q;

    // NOTE: every flop is written with <= so all state updates see pre-edge values.
    always_ff @(posedge pclock18 or negedge preset18) begin
        if (!preset18) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: each always_comb assigns a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d = (WAIT_STATES18 == 0) ? ACCESS_DONE : ACCESS_WAIT;
                end
            end
            ACCESS_WAIT: begin
                if (!sel) begin
                    state_d = IDLE;
                end else if (penable18 && cnt_q <= 4'd1) begin
                    state_d = ACCESS_DONE;
                end
            end
            ACCESS_DONE: begin
                if (!sel || penable18) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pready18  = (state_q == ACCESS_DONE) && sel && penable18;
        pslverr18 = pready18 && err_q;
        prdata18  = '0;
        if (pready18 && !wr_q && !err_q) begin
            prdata18 = PRDATA_WIDTH18'(rd_word);
        end
    end

    // The transfer is fully described by what was on the bus at setup.
    always_comb begin
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        err_d   = err_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        if (state_q == IDLE && setup) begin
            cnt_d   = WAIT_LOAD;
            wr_d    = prwd18;
            err_d   = (paddr18 >= PADDR_WIDTH18'(32'h20)) || (paddr18[1:0] != 2'b00);
            idx_d   = paddr18[4:2];
            wdata_d = 32'(pwdata18);
        end else if (state_q == ACCESS_WAIT && sel && penable18 && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge pclock18 or negedge preset18) begin
        if (!preset18) begin
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        rd_word = '0;
        unique case (idx_q)
            3'd0:    rd_word = {24'd0, ctrl_q};
            3'd1:    rd_word = {24'd0, status_q};
            3'd2:    rd_word = {24'd0, mask_q};
            3'd3:    rd_word = scratch_q[0];
            3'd4:    rd_word = scratch_q[1];
            3'd5:    rd_word = scratch_q[2];
            3'd6:    rd_word = scratch_q[3];
            default: rd_word = scratch_q[4];
        endcase
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        mask_d     = mask_q;
        scratch_d  = scratch_q;
        status_clr = '0;
        if (commit) begin
            unique case (idx_q)
                3'd0:    ctrl_d       = wdata_q[7:0];
                3'd1:    status_clr   = wdata_q[7:0];
                3'd2:    mask_d       = wdata_q[7:0];
                3'd3:    scratch_d[0] = wdata_q;
                3'd4:    scratch_d[1] = wdata_q;
                3'd5:    scratch_d[2] = wdata_q;
                3'd6:    scratch_d[3] = wdata_q;
                default: scratch_d[4] = wdata_q;
            endcase
        end
        // A hardware event in the same cycle as a W1C write keeps the bit set.
        status_d = (status_q & ~status_clr) | hw_event18;
        irq_d    = ctrl_q[0] && |(status_q & mask_q);
    end

    // NOTE: the scratch array is reset like ordinary flops; it is small and must read 0 after reset.
    always_ff @(posedge pclock18 or negedge preset18) begin
        if (!preset18) begin
            ctrl_q   <= '0;
            status_q <= '0;
            mask_q   <= '0;
            irq_q    <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                scratch_q[i] <= '0;
            end
        end else begin
            ctrl_q    <= ctrl_d;
            status_q  <= status_d;
            mask_q    <= mask_d;
            irq_q     <= irq_d;
            scratch_q <= scratch_d;
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile18.sv
// Directed bench for apb_slave_regfile18: one instance with one wait state and
// one with zero wait states on a shared APB bus, checked through a scoreboard.
module tb_apb_slave_regfile18;

    logic        pclock18 = 1'b0;
    logic        preset18;
    logic [31:0] paddr18;
    logic        prwd18;
    logic [31:0] pwdata18;
    logic        penable18;
    logic [15:0] psel18;
    logic [7:0]  hw_event18;

    logic        w1_pready, w0_pready;
    logic [31:0] w1_prdata, w0_prdata;
    logic        w1_pslverr, w0_pslverr;
    logic        w1_irq, w0_irq;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cycles;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 pclock18 = ~pclock18;

    apb_slave_regfile18 #(
        .PADDR_WIDTH18(32), .PWDATA_WIDTH18(32), .PRDATA_WIDTH18(32),
        .PSEL_INDEX18(0), .WAIT_STATES18(1)
    ) dut (
        .pclock18(pclock18), .preset18(preset18), .paddr18(paddr18), .prwd18(prwd18),
        .pwdata18(pwdata18), .penable18(penable18), .psel18(psel18), .hw_event18(hw_event18),
        .pready18(w1_pready), .prdata18(w1_prdata), .pslverr18(w1_pslverr), .irq18(w1_irq)
    );

    apb_slave_regfile18 #(
        .PADDR_WIDTH18(32), .PWDATA_WIDTH18(32), .PRDATA_WIDTH18(32),
        .PSEL_INDEX18(2), .WAIT_STATES18(0)
    ) dut0 (
        .pclock18(pclock18), .preset18(preset18), .paddr18(paddr18), .prwd18(prwd18),
        .pwdata18(pwdata18), .penable18(penable18), .psel18(psel18), .hw_event18(hw_event18),
        .pready18(w0_pready), .prdata18(w0_prdata), .pslverr18(w0_pslverr), .irq18(w0_irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit to0);
        return to0 ? w0_pready : w1_pready;
    endfunction

    function automatic logic [31:0] rdat(input bit to0);
        return to0 ? w0_prdata : w1_prdata;
    endfunction

    function automatic logic serr(input bit to0);
        return to0 ? w0_pslverr : w1_pslverr;
    endfunction

    // Drives one transfer; the bus is scrambled after setup so only captured values may matter.
    task automatic apb_xfer(input bit to0, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] exp_rd,
                            input logic exp_err, input int exp_cyc, input string tag);
        exp_t e;
        int   cyc;
        bit   got;
        sb.push_back('{rdata: exp_rd, err: exp_err, cycles: exp_cyc});
        psel18    = to0 ? 16'h0004 : 16'h0001;
        paddr18   = addr;
        prwd18    = wr;
        pwdata18  = data;
        penable18 = 1'b0;
        @(posedge pclock18); #1;
        penable18 = 1'b1;
        paddr18   = ~addr;
        pwdata18  = ~data;
        prwd18    = ~wr;
        cyc = 2;
        got = 1'b0;
        while (!got && cyc <= 20) begin
            @(negedge pclock18);
            if (rdy(to0)) begin
                got = 1'b1;
            end else begin
                @(posedge pclock18); #1;
                cyc++;
            end
        end
        check({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
        e = sb.pop_front();
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_cyc"}, cyc, e.cycles);
        check({tag, "_rd"}, rdat(to0), e.rdata);
        check({tag, "_err"}, 32'(serr(to0)), 32'(e.err));
        @(posedge pclock18); #1;
    endtask

    task automatic bus_idle();
        psel18    = '0;
        penable18 = 1'b0;
        prwd18    = 1'b0;
        @(posedge pclock18); #1;
    endtask

    task automatic watch_quiet(input int n, input string tag);
        bit seen = 1'b0;
        repeat (n) begin
            @(negedge pclock18);
            if (w1_pready || w0_pready) seen = 1'b1;
            @(posedge pclock18); #1;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        preset18   = 1'b0;
        paddr18    = '0;
        prwd18     = 1'b0;
        pwdata18   = '0;
        penable18  = 1'b0;
        psel18     = '0;
        hw_event18 = '0;

        #12;
        check("rst_w1_pready",  32'(w1_pready),  32'd0);
        check("rst_w1_prdata",  w1_prdata,       32'd0);
        check("rst_w1_pslverr", 32'(w1_pslverr), 32'd0);
        check("rst_w1_irq",     32'(w1_irq),     32'd0);
        check("rst_w0_pready",  32'(w0_pready),  32'd0);
        check("rst_w0_prdata",  w0_prdata,       32'd0);
        check("rst_w0_pslverr", 32'(w0_pslverr), 32'd0);
        check("rst_w0_irq",     32'(w0_irq),     32'd0);
        #10 preset18 = 1'b1;
        @(posedge pclock18); #1;

        // Basic write/read with one wait state: pready on the third cycle.
        apb_xfer(0, 1, 32'h0C, 32'hDEADBEEF, 32'h0, 0, 3, "wr_s0");
        bus_idle();
        apb_xfer(0, 0, 32'h0C, 32'h0, 32'hDEADBEEF, 0, 3, "rd_s0");
        bus_idle();

        // Error responses leave storage untouched.
        apb_xfer(0, 0, 32'h40, 32'h0, 32'h0, 1, 3, "rd_oob");
        apb_xfer(0, 1, 32'h0E, 32'h11111111, 32'h0, 1, 3, "wr_unal");
        apb_xfer(0, 0, 32'h0C, 32'h0, 32'hDEADBEEF, 0, 3, "rd_s0_kept");
        apb_xfer(0, 1, 32'h1C, 32'hA5A5A5A5, 32'h0, 0, 3, "wr_s4");
        apb_xfer(0, 0, 32'h1C, 32'h0, 32'hA5A5A5A5, 0, 3, "rd_s4");
        apb_xfer(0, 1, 32'h20, 32'h99999999, 32'h0, 1, 3, "wr_edge");
        bus_idle();

        // Narrow registers read back only their implemented bits.
        apb_xfer(0, 1, 32'h00, 32'hABCDEF01, 32'h0, 0, 3, "wr_ctrl");
        apb_xfer(0, 0, 32'h00, 32'h0, 32'h01, 0, 3, "rd_ctrl");
        apb_xfer(0, 1, 32'h08, 32'hFFFFFF04, 32'h0, 0, 3, "wr_mask");
        apb_xfer(0, 0, 32'h08, 32'h0, 32'h04, 0, 3, "rd_mask");
        bus_idle();
        check("irq_quiet", 32'(w1_irq), 32'd0);

        // Event pulse raises irq; W1C clears it.
        hw_event18 = 8'h04;
        @(posedge pclock18); #1;
        hw_event18 = 8'h00;
        @(posedge pclock18); #1;
        @(negedge pclock18);
        check("irq_set", 32'(w1_irq), 32'd1);
        @(posedge pclock18); #1;
        apb_xfer(0, 0, 32'h04, 32'h0, 32'h04, 0, 3, "rd_status_set");
        apb_xfer(0, 1, 32'h04, 32'h04, 32'h0, 0, 3, "w1c_status");
        bus_idle();
        @(negedge pclock18);
        check("irq_clr", 32'(w1_irq), 32'd0);
        @(posedge pclock18); #1;
        apb_xfer(0, 0, 32'h04, 32'h0, 32'h00, 0, 3, "rd_status_clr");
        bus_idle();

        // Event held across a clearing write: set wins.
        hw_event18 = 8'h04;
        @(posedge pclock18); #1;
        apb_xfer(0, 1, 32'h04, 32'h04, 32'h0, 0, 3, "w1c_race");
        hw_event18 = 8'h00;
        bus_idle();
        apb_xfer(0, 0, 32'h04, 32'h0, 32'h04, 0, 3, "rd_status_race");
        bus_idle();
        check("irq_race", 32'(w1_irq), 32'd1);

        // W1C of one bit keeps the others.
        hw_event18 = 8'h81;
        @(posedge pclock18); #1;
        hw_event18 = 8'h00;
        apb_xfer(0, 1, 32'h04, 32'h01, 32'h0, 0, 3, "w1c_bit0");
        apb_xfer(0, 0, 32'h04, 32'h0, 32'h84, 0, 3, "rd_status_84");
        bus_idle();
        check("irq_still", 32'(w1_irq), 32'd1);

        // Reset during the wait cycle of a write abandons it.
        psel18    = 16'h0001;
        paddr18   = 32'h10;
        prwd18    = 1'b1;
        pwdata18  = 32'h12345678;
        penable18 = 1'b0;
        @(posedge pclock18); #1;
        penable18 = 1'b1;
        #2 preset18 = 1'b0;
        #1;
        check("rst_mid_pready", 32'(w1_pready), 32'd0);
        check("rst_mid_irq",    32'(w1_irq),    32'd0);
        psel18    = '0;
        penable18 = 1'b0;
        prwd18    = 1'b0;
        repeat (2) @(posedge pclock18);
        #3 preset18 = 1'b1;
        @(posedge pclock18); #1;
        apb_xfer(0, 0, 32'h10, 32'h0, 32'h0, 0, 3, "rd_s1_after_rst");
        apb_xfer(0, 0, 32'h00, 32'h0, 32'h0, 0, 3, "rd_ctrl_after_rst");
        apb_xfer(0, 0, 32'h04, 32'h0, 32'h0, 0, 3, "rd_status_after_rst");
        bus_idle();

        // A select bit belonging to another slave is ignored.
        psel18    = 16'h0002;
        paddr18   = 32'h0C;
        prwd18    = 1'b1;
        pwdata18  = 32'hCAFEF00D;
        penable18 = 1'b0;
        @(posedge pclock18); #1;
        penable18 = 1'b1;
        watch_quiet(4, "psel_other");
        bus_idle();

        // Access phase without setup.
        psel18    = 16'h0001;
        paddr18   = 32'h0C;
        prwd18    = 1'b1;
        pwdata18  = 32'h77777777;
        penable18 = 1'b1;
        watch_quiet(3, "no_setup");
        bus_idle();

        // Select dropped during the wait cycle.
        psel18    = 16'h0001;
        paddr18   = 32'h0C;
        prwd18    = 1'b1;
        pwdata18  = 32'h55555555;
        penable18 = 1'b0;
        @(posedge pclock18); #1;
        penable18 = 1'b1;
        psel18    = '0;
        watch_quiet(3, "sel_drop");
        bus_idle();
        apb_xfer(0, 0, 32'h0C, 32'h0, 32'h0, 0, 3, "rd_s0_untouched");
        bus_idle();

        // Zero wait states: back-to-back writes and reads, two cycles each.
        apb_xfer(1, 1, 32'h0C, 32'h0C0C0C0C, 32'h0, 0, 2, "z_wr0");
        apb_xfer(1, 1, 32'h10, 32'h10101010, 32'h0, 0, 2, "z_wr1");
        apb_xfer(1, 1, 32'h14, 32'h14141414, 32'h0, 0, 2, "z_wr2");
        apb_xfer(1, 0, 32'h0C, 32'h0, 32'h0C0C0C0C, 0, 2, "z_rd0");
        apb_xfer(1, 0, 32'h10, 32'h0, 32'h10101010, 0, 2, "z_rd1");
        apb_xfer(1, 0, 32'h14, 32'h0, 32'h14141414, 0, 2, "z_rd2");
        apb_xfer(1, 0, 32'h41, 32'h0, 32'h0, 1, 2, "z_rd_err");
        bus_idle();
        apb_xfer(0, 0, 32'h14, 32'h0, 32'h0, 0, 3, "w1_s2_untouched");
        bus_idle();

        check("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
